// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: command, status and SPI pin bundle for spi_master_multi.
// Latency: none, wires only.
// Backpressure: busy from the master refuses new commands until the cycle after done_M.
// Ports: master modport = the SPI master block; slave modport = command source / pin-side environment.
interface spi_master_multi_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CS     = 2,
   parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
   logic                  transmit;
   logic                  d_valid;
   logic [DATA_WIDTH-1:0] data_M;
   logic [CS_W-1:0]       cs_sel;
   logic                  cpol;
   logic                  cpha;
   logic                  MISO;
   logic                  MOSI;
   logic                  SCLK;
   logic [NUM_CS-1:0]     CS;
   logic                  busy;
   logic                  done_M;
   logic [DATA_WIDTH-1:0] rx_M;

   modport master (
      input  transmit, d_valid, data_M, cs_sel, cpol, cpha, MISO,
      output MOSI, SCLK, CS, busy, done_M, rx_M
   );

   modport slave (
      output transmit, d_valid, data_M, cs_sel, cpol, cpha, MISO,
      input  MOSI, SCLK, CS, busy, done_M, rx_M
   );
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with configurable width, SCLK divider, chip selects, per-transfer CPOL/CPHA.
// Latency: done_M pulses (2*DATA_WIDTH+2)*CLK_DIV+1 CLK cycles after the accepting edge.
// Backpressure: one transfer at a time; transmit&d_valid sampled only in IDLE, busy marks refusal.
// Ports: CLK, reset_n (async, active-low); bus = master modport (command in, SPI pins, busy/done_M/rx_M out).
module spi_master_multi #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter int NUM_CS     = 2,
   parameter int LSB_FIRST  = 0
) (
   input  logic               CLK,
   input  logic               reset_n,
   spi_master_multi_if.master bus
);
   localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [EDGE_W-1:0]     edge_q;      // SCLK edges already produced in this transfer
   logic [DATA_WIDTH-1:0] tx_q;        // bits still to be driven on MOSI
   logic [DATA_WIDTH-1:0] rx_q;
   logic [CS_W-1:0]       cs_sh_q;
   logic                  cpol_q, cpha_q;
   logic                  sclk_q, mosi_q;
   logic                  smp_q;       // a sampling edge was issued last cycle

   logic                  sclk_o, mosi_o, busy_o, done_o;
   logic [NUM_CS-1:0]     cs_o;
   logic [DATA_WIDTH-1:0] rx_o;

   logic                  half_end, leading, last_edge, xfer_act;
   logic                  accept, tick, do_shift, do_sample;
   logic [NUM_CS-1:0]     cs_d;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
      return (LSB_FIRST != 0) ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
      return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
      return (LSB_FIRST != 0) ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   assign half_end  = (cnt_q == CNT_LAST);
   assign leading   = ~edge_q[0];           // edges 1,3,5.. move away from cpol
   assign last_edge = (edge_q == EDGE_LAST);
   assign xfer_act  = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      tick      = 1'b0;
      do_shift  = 1'b0;
      do_sample = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.transmit && bus.d_valid) begin
               accept  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: if (half_end) state_d = XFER;
         XFER: begin
            if (half_end) begin
               tick = 1'b1;
               if (cpha_q) begin
                  do_shift  = leading;
                  do_sample = ~leading;
               end else begin
                  do_sample = leading;
                  do_shift  = ~leading & ~last_edge;
               end
               if (last_edge) state_d = HOLD;
            end
         end
         HOLD: if (half_end) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An out-of-range cs_sel simply matches no line.
   always_comb begin
      cs_d = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (xfer_act && (int'(cs_sh_q) == i)) cs_d[i] = 1'b0;
      end
   end

   // Pins are registered one cycle behind the internal shift/SCLK state. MISO is shifted in
   // on the cycle after a sampling edge was issued, i.e. on the edge where that SCLK
   // transition actually appears on the pin.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cs_sh_q <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         smp_q   <= 1'b0;
         sclk_o  <= 1'b0;
         mosi_o  <= 1'b0;
         cs_o    <= '1;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         rx_o    <= '0;
      end else begin
         if (xfer_act) cnt_q <= half_end ? '0 : cnt_q + 1'b1;
         else          cnt_q <= '0;
         smp_q <= do_sample;

         if (accept) begin
            cs_sh_q <= bus.cs_sel;
            cpol_q  <= bus.cpol;
            cpha_q  <= bus.cpha;
            sclk_q  <= bus.cpol;
            edge_q  <= '0;
            rx_q    <= '0;
            if (!bus.cpha) begin
               mosi_q <= first_bit(bus.data_M);
               tx_q   <= shift_out(bus.data_M);
            end else begin
               tx_q   <= bus.data_M;
            end
         end else begin
            if (state_q == IDLE) sclk_q <= cpol_q;
            if (tick) begin
               sclk_q <= ~sclk_q;
               edge_q <= edge_q + 1'b1;
            end
            if (do_shift) begin
               mosi_q <= first_bit(tx_q);
               tx_q   <= shift_out(tx_q);
            end
            if (smp_q) rx_q <= shift_in(rx_q, bus.MISO);
         end

         sclk_o <= sclk_q;
         mosi_o <= mosi_q;
         cs_o   <= cs_d;
         busy_o <= xfer_act;
         done_o <= (state_q == DONE);
         if (state_q == DONE) rx_o <= rx_q;
      end
   end

   assign bus.SCLK   = sclk_o;
   assign bus.MOSI   = mosi_o;
   assign bus.CS     = cs_o;
   assign bus.busy   = busy_o;
   assign bus.done_M = done_o;
   assign bus.rx_M   = rx_o;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed bench for spi_master_multi on three parameter sets.
// dut_a: 8-bit, 2 CS, MSB first; dut_b: 8-bit, 4 CS; dut_c: 16-bit, 3 CS, LSB first.
// dut_a MISO is either looped from MOSI or driven by a small mode-3 slave model.
module tb_spi_master_multi;
   logic CLK = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   spi_master_multi_if #(.DATA_WIDTH(8),  .NUM_CS(2)) ifa ();
   spi_master_multi_if #(.DATA_WIDTH(8),  .NUM_CS(4)) ifb ();
   spi_master_multi_if #(.DATA_WIDTH(16), .NUM_CS(3)) ifc ();

   spi_master_multi #(.DATA_WIDTH(8),  .CLK_DIV(2), .NUM_CS(2), .LSB_FIRST(0))
      dut_a (.CLK(CLK), .reset_n(reset_n), .bus(ifa.master));
   spi_master_multi #(.DATA_WIDTH(8),  .CLK_DIV(2), .NUM_CS(4), .LSB_FIRST(0))
      dut_b (.CLK(CLK), .reset_n(reset_n), .bus(ifb.master));
   spi_master_multi #(.DATA_WIDTH(16), .CLK_DIV(2), .NUM_CS(3), .LSB_FIRST(1))
      dut_c (.CLK(CLK), .reset_n(reset_n), .bus(ifc.master));

   // Mode-3 slave: drives on falling (leading) edges, samples MOSI on rising (trailing) edges.
   logic       use_slave, slv_clr, slv_miso;
   logic [7:0] slv_tx, slv_rx;

   always @(negedge ifa.SCLK or posedge slv_clr) begin
      if (slv_clr) begin
         slv_tx   <= 8'hCA;
         slv_miso <= 1'b0;
      end else begin
         slv_miso <= slv_tx[7];
         slv_tx   <= {slv_tx[6:0], 1'b0};
      end
   end

   always @(posedge ifa.SCLK) slv_rx <= {slv_rx[6:0], ifa.MOSI};

   assign ifa.MISO = use_slave ? slv_miso : ifa.MOSI;
   assign ifb.MISO = ifb.MOSI;
   assign ifc.MISO = ifc.MOSI;

   task automatic idle_inputs();
      ifa.transmit = 0; ifa.d_valid = 0; ifa.data_M = '0; ifa.cs_sel = '0; ifa.cpol = 0; ifa.cpha = 0;
      ifb.transmit = 0; ifb.d_valid = 0; ifb.data_M = '0; ifb.cs_sel = '0; ifb.cpol = 0; ifb.cpha = 0;
      ifc.transmit = 0; ifc.d_valid = 0; ifc.data_M = '0; ifc.cs_sel = '0; ifc.cpol = 0; ifc.cpha = 0;
   endtask

   task automatic test_reset();
      reset_n = 0; use_slave = 0; slv_clr = 1;
      idle_inputs();
      repeat (3) @(negedge CLK);
      total++; if (ifa.CS !== 2'b11)   begin bad++; $display("FAIL reset_cs_a got=%b want=11", ifa.CS); end
      total++; if (ifa.SCLK !== 1'b0)  begin bad++; $display("FAIL reset_sclk got=%b want=0", ifa.SCLK); end
      total++; if (ifa.MOSI !== 1'b0)  begin bad++; $display("FAIL reset_mosi got=%b want=0", ifa.MOSI); end
      total++; if (ifa.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
      total++; if (ifa.done_M !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", ifa.done_M); end
      total++; if (ifa.rx_M !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", ifa.rx_M); end
      total++; if (ifb.CS !== 4'hF)    begin bad++; $display("FAIL reset_cs_b got=%b want=1111", ifb.CS); end
      total++; if (ifc.CS !== 3'b111)  begin bad++; $display("FAIL reset_cs_c got=%b want=111", ifc.CS); end
      reset_n = 1; slv_clr = 0;
      @(negedge CLK);
   endtask

   // Mode 0 loopback; command inputs are scrambled while busy and must not matter.
   task automatic test_mode0_loopback();
      int cyc = 0, edges = 0, cs_bad = 0;
      logic prev, got = 0, busy_d, sclk_d;
      logic [1:0] cs_at;
      ifa.data_M = 8'hB3; ifa.cs_sel = 0; ifa.cpol = 0; ifa.cpha = 0; ifa.transmit = 1; ifa.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifa.transmit = 0; ifa.data_M = 8'hFF; ifa.cpol = 1; ifa.cpha = 1; ifa.cs_sel = 1'b1;
      prev = ifa.SCLK;
      while (!got && cyc < 200) begin
         @(negedge CLK); cyc++;
         if (ifa.SCLK !== prev) edges++;
         prev = ifa.SCLK;
         if (ifa.busy === 1'b1 && ifa.CS !== 2'b10) cs_bad++;
         if (ifa.done_M === 1'b1) got = 1;
      end
      busy_d = ifa.busy; sclk_d = ifa.SCLK; cs_at = ifa.CS;
      total++; if (!got || cyc != 37) begin bad++; $display("FAIL m0_latency got=%0d want=37", cyc); end
      total++; if (edges != 16)       begin bad++; $display("FAIL m0_edges got=%0d want=16", edges); end
      total++; if (cs_bad != 0)       begin bad++; $display("FAIL m0_cs_busy badcycles=%0d want=0", cs_bad); end
      total++; if (ifa.rx_M !== 8'hB3) begin bad++; $display("FAIL m0_rx got=%h want=b3", ifa.rx_M); end
      total++; if (busy_d !== 1'b0)   begin bad++; $display("FAIL m0_busy_at_done got=%b want=0", busy_d); end
      total++; if (cs_at !== 2'b11)   begin bad++; $display("FAIL m0_cs_at_done got=%b want=11", cs_at); end
      total++; if (sclk_d !== 1'b0)   begin bad++; $display("FAIL m0_sclk_idle got=%b want=0", sclk_d); end
      @(negedge CLK);
      total++; if (ifa.done_M !== 1'b0) begin bad++; $display("FAIL m0_done_pulse got=%b want=0", ifa.done_M); end
      total++; if (ifa.rx_M !== 8'hB3) begin bad++; $display("FAIL m0_rx_hold got=%h want=b3", ifa.rx_M); end
      ifa.d_valid = 0; ifa.cpol = 0; ifa.cpha = 0; ifa.cs_sel = 0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_mode3_slave();
      int cyc = 0, edges = 0;
      logic prev = 0, got = 0, sclk_setup = 0;
      slv_clr = 1; #1 slv_clr = 0;
      use_slave = 1;
      ifa.data_M = 8'h5C; ifa.cs_sel = 0; ifa.cpol = 1; ifa.cpha = 1; ifa.transmit = 1; ifa.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifa.transmit = 0; ifa.d_valid = 0;
      while (!got && cyc < 200) begin
         @(negedge CLK); cyc++;
         if (cyc == 1) sclk_setup = ifa.SCLK;
         else if (ifa.SCLK !== prev) edges++;
         prev = ifa.SCLK;
         if (ifa.done_M === 1'b1) got = 1;
      end
      total++; if (sclk_setup !== 1'b1) begin bad++; $display("FAIL m3_sclk_before got=%b want=1", sclk_setup); end
      total++; if (!got || cyc != 37)   begin bad++; $display("FAIL m3_latency got=%0d want=37", cyc); end
      total++; if (edges != 16)         begin bad++; $display("FAIL m3_edges got=%0d want=16", edges); end
      total++; if (ifa.rx_M !== 8'hCA)  begin bad++; $display("FAIL m3_rx got=%h want=ca", ifa.rx_M); end
      total++; if (slv_rx !== 8'h5C)    begin bad++; $display("FAIL m3_slave_rx got=%h want=5c", slv_rx); end
      repeat (3) @(negedge CLK);
      total++; if (ifa.SCLK !== 1'b1)   begin bad++; $display("FAIL m3_sclk_after got=%b want=1", ifa.SCLK); end
      use_slave = 0; ifa.cpol = 0; ifa.cpha = 0;
      @(negedge CLK);
   endtask

   task automatic test_cs_decode();
      int cyc = 0, cs_lo = 0, cs_bad = 0;
      logic got = 0;
      ifb.data_M = 8'h3C; ifb.cs_sel = 2'd2; ifb.transmit = 1; ifb.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifb.transmit = 0; ifb.d_valid = 0;
      while (!got && cyc < 200) begin
         @(negedge CLK); cyc++;
         if (ifb.CS === 4'b1011) cs_lo++;
         if (ifb.CS !== (ifb.busy ? 4'b1011 : 4'b1111)) cs_bad++;
         if (ifb.done_M === 1'b1) got = 1;
      end
      total++; if (!got || cyc != 37) begin bad++; $display("FAIL cs4_latency got=%0d want=37", cyc); end
      total++; if (cs_lo != 36)       begin bad++; $display("FAIL cs4_sel_cycles got=%0d want=36", cs_lo); end
      total++; if (cs_bad != 0)       begin bad++; $display("FAIL cs4_pattern badcycles=%0d want=0", cs_bad); end
      total++; if (ifb.rx_M !== 8'h3C) begin bad++; $display("FAIL cs4_rx got=%h want=3c", ifb.rx_M); end

      cyc = 0; cs_bad = 0; got = 0;
      ifc.data_M = 16'h1234; ifc.cs_sel = 2'd3; ifc.transmit = 1; ifc.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.transmit = 0; ifc.d_valid = 0;
      while (!got && cyc < 300) begin
         @(negedge CLK); cyc++;
         if (ifc.CS !== 3'b111) cs_bad++;
         if (ifc.done_M === 1'b1) got = 1;
      end
      total++; if (!got || cyc != 69)   begin bad++; $display("FAIL cs_oor_latency got=%0d want=69", cyc); end
      total++; if (cs_bad != 0)         begin bad++; $display("FAIL cs_oor_asserted badcycles=%0d want=0", cs_bad); end
      total++; if (ifc.rx_M !== 16'h1234) begin bad++; $display("FAIL cs_oor_rx got=%h want=1234", ifc.rx_M); end
      @(negedge CLK);
   endtask

   task automatic test_lsb16();
      int cyc = 0, nb = 0, cs_bad = 0;
      logic prev = 0, got = 0;
      logic [15:0] seq = '0;
      ifc.data_M = 16'h8001; ifc.cs_sel = 2'd0; ifc.transmit = 1; ifc.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.transmit = 0; ifc.d_valid = 0;
      while (!got && cyc < 300) begin
         @(negedge CLK); cyc++;
         if (prev === 1'b0 && ifc.SCLK === 1'b1) begin
            if (nb < 16) seq[nb] = ifc.MOSI;
            nb++;
         end
         prev = ifc.SCLK;
         if (ifc.busy === 1'b1 && ifc.CS !== 3'b110) cs_bad++;
         if (ifc.done_M === 1'b1) got = 1;
      end
      total++; if (!got || cyc != 69)  begin bad++; $display("FAIL lsb_latency got=%0d want=69", cyc); end
      total++; if (nb != 16)           begin bad++; $display("FAIL lsb_leading_edges got=%0d want=16", nb); end
      total++; if (seq !== 16'h8001)   begin bad++; $display("FAIL lsb_mosi_seq got=%h want=8001", seq); end
      total++; if (ifc.rx_M !== 16'h8001) begin bad++; $display("FAIL lsb_rx got=%h want=8001", ifc.rx_M); end
      total++; if (cs_bad != 0)        begin bad++; $display("FAIL lsb_cs badcycles=%0d want=0", cs_bad); end
      @(negedge CLK);
   endtask

   // Request held high: second word accepted on the edge ending the first done_M cycle.
   task automatic test_back_to_back();
      int cyc = 0, ndone = 0, d1 = -1, d2 = -1;
      logic [7:0] rx1 = '0, rx2 = '0;
      logic busy37 = 1'bx, busy39 = 1'bx;
      ifa.data_M = 8'h11; ifa.cs_sel = 0; ifa.cpol = 0; ifa.cpha = 0; ifa.transmit = 1; ifa.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      while (cyc < 90) begin
         @(negedge CLK); cyc++;
         if (cyc == 1) ifa.data_M = 8'h22;
         if (cyc == 37) busy37 = ifa.busy;
         if (cyc == 39) busy39 = ifa.busy;
         if (ifa.done_M === 1'b1) begin
            ndone++;
            if (ndone == 1) begin d1 = cyc; rx1 = ifa.rx_M; end
            if (ndone == 2) begin d2 = cyc; rx2 = ifa.rx_M; ifa.transmit = 0; ifa.d_valid = 0; end
         end
      end
      ifa.transmit = 0; ifa.d_valid = 0;
      total++; if (ndone != 2)      begin bad++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
      total++; if (d1 != 37)        begin bad++; $display("FAIL b2b_first_done got=%0d want=37", d1); end
      total++; if (d2 != 75)        begin bad++; $display("FAIL b2b_second_done got=%0d want=75", d2); end
      total++; if (rx1 !== 8'h11)   begin bad++; $display("FAIL b2b_rx1 got=%h want=11", rx1); end
      total++; if (rx2 !== 8'h22)   begin bad++; $display("FAIL b2b_rx2 got=%h want=22", rx2); end
      total++; if (busy37 !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_done got=%b want=0", busy37); end
      total++; if (busy39 !== 1'b1) begin bad++; $display("FAIL b2b_busy_second got=%b want=1", busy39); end
   endtask

   task automatic test_reset_abort();
      int cyc = 0, edges = 0, ndone = 0;
      logic prev;
      ifa.data_M = 8'hA5; ifa.cs_sel = 0; ifa.cpol = 0; ifa.cpha = 0; ifa.transmit = 1; ifa.d_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      ifa.transmit = 0; ifa.d_valid = 0;
      prev = ifa.SCLK;
      while (edges < 5 && cyc < 100) begin
         @(negedge CLK); cyc++;
         if (ifa.SCLK !== prev) edges++;
         prev = ifa.SCLK;
         if (ifa.done_M === 1'b1) ndone++;
      end
      total++; if (edges != 5) begin bad++; $display("FAIL abort_reach_edge5 got=%0d want=5", edges); end
      reset_n = 0;
      #1;
      total++; if (ifa.CS !== 2'b11)    begin bad++; $display("FAIL abort_cs got=%b want=11", ifa.CS); end
      total++; if (ifa.SCLK !== 1'b0)   begin bad++; $display("FAIL abort_sclk got=%b want=0", ifa.SCLK); end
      total++; if (ifa.busy !== 1'b0)   begin bad++; $display("FAIL abort_busy got=%b want=0", ifa.busy); end
      total++; if (ifa.rx_M !== 8'h00)  begin bad++; $display("FAIL abort_rx got=%h want=00", ifa.rx_M); end
      @(negedge CLK);
      reset_n = 1;
      repeat (60) begin
         @(negedge CLK);
         if (ifa.done_M === 1'b1) ndone++;
      end
      total++; if (ndone != 0)        begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b want=0", ifa.busy); end
   endtask

   initial begin
      test_reset();
      test_mode0_loopback();
      test_mode3_slave();
      test_cs_decode();
      test_lsb16();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
